// File: rtl/fp16_pkg.sv
// ---------------------------------------------------------------------------
// fp16_pkg
// Shared definitions for the binary16 multiplier back end: field widths,
// exponent limits, special encodings, the operand/result class enum and the
// record passed from stage 1 to stage 2 of fp16_mul_round.
// ---------------------------------------------------------------------------
package fp16_pkg;

   localparam int EXP_W  = 5;
   localparam int FRAC_W = 10;

   // Exponent constants are 8-bit so they line up with the signed
   // stage-1 exponent without width conversion.
   localparam logic        [7:0] BIAS    = 8'd15;
   localparam logic signed [7:0] EXP_MAX = 8'sd31;

   localparam logic [15:0] QNAN    = 16'h7E00;
   localparam logic [15:0] POS_INF = 16'h7C00;

   typedef enum logic [1:0] {
      ZERO   = 2'd0,
      NORMAL = 2'd1,
      INF    = 2'd2,
      NAN    = 2'd3
   } fp_class_e;

   // cls is the class of the final result: specials are resolved in
   // stage 1, NORMAL means stage 2 must round and range-check.
   typedef struct packed {
      logic              sign;
      fp_class_e         cls;
      logic signed [7:0] exp;
      logic [10:0]       keep;
      logic              guard;
      logic              sticky;
   } s1_rec_t;

endpackage

// File: rtl/fp16_classify.sv
// ---------------------------------------------------------------------------
// fp16_classify
// Combinational split of one binary16 operand into class, exponent and
// fraction fields. Subnormal encodings (exp=0) are classed as ZERO.
//   op          in   16  binary16 operand
//   cls         out   2  ZERO / NORMAL / INF / NAN
//   exp_field   out   5  biased exponent
//   frac_field  out  10  stored fraction
// ---------------------------------------------------------------------------
module fp16_classify
   import fp16_pkg::*;
(
   input  logic [15:0]       op,
   output fp_class_e         cls,
   output logic [EXP_W-1:0]  exp_field,
   output logic [FRAC_W-1:0] frac_field
);

   assign exp_field  = op[14:10];
   assign frac_field = op[9:0];

   always_comb begin
      if (exp_field == '0)
         cls = ZERO;
      else if (exp_field == '1)
         cls = (frac_field != '0) ? NAN : INF;
      else
         cls = NORMAL;
   end

endmodule

// File: rtl/fp16_mul_round.sv
// ---------------------------------------------------------------------------
// fp16_mul_round
// Normalize / round / pack stage of the binary16 multiplier. Two pipeline
// registers (s1: classification and unrounded significand, s2: packed result
// and flags) with valid/ready handshakes on both sides.
//   iClk        in    1  clock
//   iRst_n      in    1  synchronous active-low reset
//   iValid      in    1  upstream transaction present
//   oReady      out   1  block accepts this cycle
//   iA, iB      in   16  original binary16 operands
//   iProd       in   32  significand product {1,fracA} x {1,fracB}
//   oValid      out   1  result present
//   iReady      in    1  downstream accepts
//   oZ          out  16  packed binary16 result
//   oInvalid, oOverflow, oUnderflow, oInexact  out  1  per-result flags
// ---------------------------------------------------------------------------
module fp16_mul_round
   import fp16_pkg::*;
(
   input  logic        iClk,
   input  logic        iRst_n,
   input  logic        iValid,
   output logic        oReady,
   input  logic [15:0] iA,
   input  logic [15:0] iB,
   input  logic [31:0] iProd,
   output logic        oValid,
   input  logic        iReady,
   output logic [15:0] oZ,
   output logic        oInvalid,
   output logic        oOverflow,
   output logic        oUnderflow,
   output logic        oInexact
);

   fp_class_e         cls_a;
   fp_class_e         cls_b;
   logic [EXP_W-1:0]  exp_a;
   logic [EXP_W-1:0]  exp_b;
   logic [FRAC_W-1:0] frac_a;
   logic [FRAC_W-1:0] frac_b;

   fp16_classify u_cls_a (
      .op         (iA),
      .cls        (cls_a),
      .exp_field  (exp_a),
      .frac_field (frac_a)
   );

   fp16_classify u_cls_b (
      .op         (iB),
      .cls        (cls_b),
      .exp_field  (exp_b),
      .frac_field (frac_b)
   );

   // The fractions are already folded into iProd, iProd[31:22] is always
   // zero and bit 10 of the rounded sum is the hidden one.
   logic unused_bits;
   logic [11:0] sig_sum;
   assign unused_bits = ^{frac_a, frac_b, iProd[31:22], sig_sum[10]};

   // -------------------------------------------------------------------
   // Handshake
   // -------------------------------------------------------------------
   logic    s1_valid;
   s1_rec_t s1_q;
   s1_rec_t s1_d;
   logic    adv_s2;
   logic    in_fire;

   assign adv_s2  = !oValid | iReady;
   assign oReady  = !s1_valid | adv_s2;
   assign in_fire = iValid & oReady;

   // -------------------------------------------------------------------
   // Stage 1: classify, exponent sum, normalize and split off guard/sticky
   // -------------------------------------------------------------------
   logic [7:0] exp_sum;

   always_comb begin
      s1_d      = '0;
      s1_d.sign = iA[15] ^ iB[15];

      if ((cls_a == NAN) || (cls_b == NAN) ||
          ((cls_a == INF) && (cls_b == ZERO)) ||
          ((cls_a == ZERO) && (cls_b == INF)))
         s1_d.cls = NAN;
      else if ((cls_a == INF) || (cls_b == INF))
         s1_d.cls = INF;
      else if ((cls_a == ZERO) || (cls_b == ZERO))
         s1_d.cls = ZERO;
      else
         s1_d.cls = NORMAL;

      exp_sum = {3'b000, exp_a} + {3'b000, exp_b} - BIAS;

      // Product of two [1,2) significands lies in [1,4); bit 21 marks [2,4).
      if (iProd[21]) begin
         s1_d.keep   = iProd[21:11];
         s1_d.guard  = iProd[10];
         s1_d.sticky = |iProd[9:0];
         s1_d.exp    = exp_sum + 8'd1;
      end else begin
         s1_d.keep   = iProd[20:10];
         s1_d.guard  = iProd[9];
         s1_d.sticky = |iProd[8:0];
         s1_d.exp    = exp_sum;
      end
   end

   // -------------------------------------------------------------------
   // Stage 2: round to nearest even, range check, pack
   // -------------------------------------------------------------------
   logic              rnd_inc;
   logic [9:0]        frac_rnd;
   logic signed [7:0] exp_rnd;
   logic [15:0]       z_d;
   logic              inv_d;
   logic              ovf_d;
   logic              unf_d;
   logic              inx_d;

   always_comb begin
      rnd_inc = s1_q.guard & (s1_q.sticky | s1_q.keep[0]);
      sig_sum = {1'b0, s1_q.keep} + {11'b0, rnd_inc};

      // Carry out of 1.111..1 renormalizes to 1.0 with the next exponent.
      if (sig_sum[11]) begin
         frac_rnd = '0;
         exp_rnd  = s1_q.exp + 8'sd1;
      end else begin
         frac_rnd = sig_sum[9:0];
         exp_rnd  = s1_q.exp;
      end

      z_d   = {s1_q.sign, 15'h0000};
      inv_d = 1'b0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inx_d = 1'b0;

      case (s1_q.cls)
         NAN: begin
            z_d   = QNAN;
            inv_d = 1'b1;
         end
         INF: begin
            z_d = {s1_q.sign, POS_INF[14:0]};
         end
         ZERO: begin
            z_d = {s1_q.sign, 15'h0000};
         end
         default: begin
            inx_d = s1_q.guard | s1_q.sticky;
            if (exp_rnd >= EXP_MAX) begin
               z_d   = {s1_q.sign, POS_INF[14:0]};
               ovf_d = 1'b1;
               inx_d = 1'b1;
            end else if (exp_rnd <= 8'sd0) begin
               z_d   = {s1_q.sign, 15'h0000};
               unf_d = 1'b1;
               inx_d = 1'b1;
            end else begin
               z_d = {s1_q.sign, exp_rnd[4:0], frac_rnd};
            end
         end
      endcase
   end

   // -------------------------------------------------------------------
   // Pipeline registers
   // -------------------------------------------------------------------
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         s1_valid   <= 1'b0;
         s1_q       <= '0;
         oValid     <= 1'b0;
         oZ         <= 16'h0000;
         oInvalid   <= 1'b0;
         oOverflow  <= 1'b0;
         oUnderflow <= 1'b0;
         oInexact   <= 1'b0;
      end else begin
         if (oReady) begin
            s1_valid <= in_fire;
            if (in_fire)
               s1_q <= s1_d;
         end
         if (adv_s2) begin
            oValid <= s1_valid;
            if (s1_valid) begin
               oZ         <= z_d;
               oInvalid   <= inv_d;
               oOverflow  <= ovf_d;
               oUnderflow <= unf_d;
               oInexact   <= inx_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_fp16_mul_round.sv
// ---------------------------------------------------------------------------
// tb_fp16_mul_round
// Directed bench for fp16_mul_round. Vector table holds operands, product
// and hand-computed result/flags ({invalid, overflow, underflow, inexact}).
// ---------------------------------------------------------------------------
module tb_fp16_mul_round;

   logic        iClk   = 1'b0;
   logic        iRst_n = 1'b0;
   logic        iValid = 1'b0;
   logic        oReady;
   logic [15:0] iA     = '0;
   logic [15:0] iB     = '0;
   logic [31:0] iProd  = '0;
   logic        oValid;
   logic        iReady = 1'b1;
   logic [15:0] oZ;
   logic        oInvalid;
   logic        oOverflow;
   logic        oUnderflow;
   logic        oInexact;
   logic [3:0]  flags;

   int checks   = 0;
   int failures = 0;

   assign flags = {oInvalid, oOverflow, oUnderflow, oInexact};

   fp16_mul_round dut (
      .iClk       (iClk),
      .iRst_n     (iRst_n),
      .iValid     (iValid),
      .oReady     (oReady),
      .iA         (iA),
      .iB         (iB),
      .iProd      (iProd),
      .oValid     (oValid),
      .iReady     (iReady),
      .oZ         (oZ),
      .oInvalid   (oInvalid),
      .oOverflow  (oOverflow),
      .oUnderflow (oUnderflow),
      .oInexact   (oInexact)
   );

   always #5 iClk = ~iClk;

   localparam int NV = 18;

   logic [15:0] va [NV] = '{
      16'h3C00, 16'h3E00, 16'h3C01, 16'h3C01, 16'h3C00, 16'h7BFF,
      16'h7800, 16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h7C00,
      16'hFC00, 16'h8000, 16'h0001, 16'hFD00, 16'h7C00, 16'h8000};
   logic [15:0] vb [NV] = '{
      16'h3C00, 16'h3E00, 16'h3E00, 16'h3C01, 16'h3C00, 16'h7BFF,
      16'h3C00, 16'h0400, 16'h3C00, 16'h3800, 16'h3800, 16'h0000,
      16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'hFC00, 16'hFC00};
   logic [31:0] vp [NV] = '{
      32'h00100000, 32'h00240000, 32'h00180600, 32'h00100801,
      32'h001FFE01, 32'h003FF001, 32'h001FFE01, 32'h00100000,
      32'h00100000, 32'h00100000, 32'h001FFE01, 32'h003FFFFF,
      32'h00155555, 32'h003FFFFF, 32'h00100400, 32'h00100000,
      32'h00000000, 32'h00100000};
   logic [15:0] vz [NV] = '{
      16'h3C00, 16'h4080, 16'h3E02, 16'h3C02, 16'h4000, 16'h7C00,
      16'h7C00, 16'h0000, 16'h0400, 16'h0000, 16'h0400, 16'h7E00,
      16'hFC00, 16'h8000, 16'h0000, 16'h7E00, 16'hFC00, 16'h7E00};
   logic [3:0]  vf [NV] = '{
      4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0101,
      4'b0101, 4'b0011, 4'b0000, 4'b0011, 4'b0001, 4'b1000,
      4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000};

   // Drive one op and collect its result; lat counts edges from accept.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] p, output logic [15:0] z,
                        output logic [3:0] fl, output int lat);
      int n;
      @(negedge iClk);
      iA = a; iB = b; iProd = p; iValid = 1'b1; iReady = 1'b1;
      #1;
      n = 0;
      while (!oReady && n < 20) begin
         @(negedge iClk); #1; n++;
      end
      @(negedge iClk);
      iValid = 1'b0; iA = '0; iB = '0; iProd = '0;
      lat = 1;
      while (!oValid && lat < 10) begin
         @(negedge iClk); lat++;
      end
      z  = oZ;
      fl = flags;
   endtask

   task automatic test_reset;
      iRst_n = 1'b0; iValid = 1'b0; iReady = 1'b1;
      repeat (2) @(negedge iClk);
      checks++;
      if (oValid !== 1'b0) begin
         failures++; $display("FAIL reset_valid got=%b exp=0", oValid);
      end
      checks++;
      if (oZ !== 16'h0000) begin
         failures++; $display("FAIL reset_z got=%h exp=0000", oZ);
      end
      checks++;
      if (flags !== 4'b0000) begin
         failures++; $display("FAIL reset_flags got=%b exp=0000", flags);
      end
      iRst_n = 1'b1;
      @(negedge iClk);
      checks++;
      if (oReady !== 1'b1) begin
         failures++; $display("FAIL reset_ready got=%b exp=1", oReady);
      end
   endtask

   task automatic test_normal;
      logic [15:0] z; logic [3:0] fl; int lat;
      for (int i = 0; i <= 4; i++) begin
         do_op(va[i], vb[i], vp[i], z, fl, lat);
         checks++;
         if (z !== vz[i]) begin
            failures++; $display("FAIL normal_z[%0d] got=%h exp=%h", i, z, vz[i]);
         end
         checks++;
         if (fl !== vf[i]) begin
            failures++; $display("FAIL normal_flags[%0d] got=%b exp=%b", i, fl, vf[i]);
         end
         checks++;
         if (lat !== 2) begin
            failures++; $display("FAIL normal_latency[%0d] got=%0d exp=2", i, lat);
         end
      end
   endtask

   task automatic test_range;
      logic [15:0] z; logic [3:0] fl; int lat;
      for (int i = 5; i <= 10; i++) begin
         do_op(va[i], vb[i], vp[i], z, fl, lat);
         checks++;
         if (z !== vz[i] || lat !== 2) begin
            failures++;
            $display("FAIL range_z[%0d] got=%h lat=%0d exp=%h lat=2", i, z, lat, vz[i]);
         end
         checks++;
         if (fl !== vf[i]) begin
            failures++; $display("FAIL range_flags[%0d] got=%b exp=%b", i, fl, vf[i]);
         end
      end
   endtask

   task automatic test_specials;
      logic [15:0] z; logic [3:0] fl; int lat;
      for (int i = 11; i < NV; i++) begin
         do_op(va[i], vb[i], vp[i], z, fl, lat);
         checks++;
         if (z !== vz[i] || lat !== 2) begin
            failures++;
            $display("FAIL special_z[%0d] got=%h lat=%0d exp=%h lat=2", i, z, lat, vz[i]);
         end
         checks++;
         if (fl !== vf[i]) begin
            failures++; $display("FAIL special_flags[%0d] got=%b exp=%b", i, fl, vf[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] prev_z;
      logic        prev_stall;
      logic        saw_drop;
      logic        extra;
      int          idx;
      int          got;
      int          cyc;
      idx = 0; got = 0; cyc = 0; prev_stall = 1'b0; saw_drop = 1'b0;
      prev_z = '0;
      @(negedge iClk);
      while (got < 8 && cyc < 60) begin
         iReady = !(cyc >= 4 && cyc <= 6);
         if (idx < 8) begin
            iValid = 1'b1; iA = va[idx]; iB = vb[idx]; iProd = vp[idx];
         end else begin
            iValid = 1'b0; iA = '0; iB = '0; iProd = '0;
         end
         #1;
         if (!oReady) saw_drop = 1'b1;
         if (prev_stall) begin
            checks++;
            if (oZ !== prev_z) begin
               failures++; $display("FAIL stall_hold got=%h exp=%h", oZ, prev_z);
            end
         end
         if (oValid && iReady) begin
            checks++;
            if (oZ !== vz[got] || flags !== vf[got]) begin
               failures++;
               $display("FAIL stream_out[%0d] got=%h/%b exp=%h/%b",
                        got, oZ, flags, vz[got], vf[got]);
            end
            got++;
         end
         prev_stall = oValid && !iReady;
         prev_z     = oZ;
         if (iValid && oReady) idx++;
         @(negedge iClk);
         cyc++;
      end
      iValid = 1'b0; iReady = 1'b1;
      checks++;
      if (got !== 8) begin
         failures++; $display("FAIL stream_count got=%0d exp=8", got);
      end
      checks++;
      if (saw_drop !== 1'b1) begin
         failures++; $display("FAIL stream_backpressure got=%b exp=1", saw_drop);
      end
      extra = 1'b0;
      repeat (4) begin
         if (oValid) extra = 1'b1;
         @(negedge iClk);
      end
      checks++;
      if (extra !== 1'b0) begin
         failures++; $display("FAIL stream_extra got=%b exp=0", extra);
      end
   endtask

   task automatic test_reset_midflight;
      logic [15:0] z; logic [3:0] fl; int lat;
      logic        leak;
      @(negedge iClk);
      iReady = 1'b0;
      iValid = 1'b1; iA = va[1]; iB = vb[1]; iProd = vp[1];
      @(negedge iClk);
      iA = va[11]; iB = vb[11]; iProd = vp[11];
      @(negedge iClk);
      iValid = 1'b0;
      checks++;
      if (oValid !== 1'b1 || oReady !== 1'b0) begin
         failures++;
         $display("FAIL inflight_setup got=valid%b/ready%b exp=valid1/ready0", oValid, oReady);
      end
      iRst_n = 1'b0;
      @(negedge iClk);
      checks++;
      if (oValid !== 1'b0 || oZ !== 16'h0000) begin
         failures++;
         $display("FAIL midreset_out got=%b/%h exp=0/0000", oValid, oZ);
      end
      checks++;
      if (flags !== 4'b0000 || oReady !== 1'b1) begin
         failures++;
         $display("FAIL midreset_flags got=%b/ready%b exp=0000/ready1", flags, oReady);
      end
      iRst_n = 1'b1; iReady = 1'b1;
      leak = 1'b0;
      repeat (4) begin
         @(negedge iClk);
         if (oValid) leak = 1'b1;
      end
      checks++;
      if (leak !== 1'b0) begin
         failures++; $display("FAIL midreset_leak got=%b exp=0", leak);
      end
      do_op(va[2], vb[2], vp[2], z, fl, lat);
      checks++;
      if (z !== vz[2] || fl !== vf[2]) begin
         failures++;
         $display("FAIL post_reset_op got=%h/%b exp=%h/%b", z, fl, vz[2], vf[2]);
      end
      checks++;
      if (lat !== 2) begin
         failures++; $display("FAIL post_reset_latency got=%0d exp=2", lat);
      end
   endtask

   initial begin
      test_reset;
      test_normal;
      test_range;
      test_specials;
      test_back_to_back;
      test_reset_midflight;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
